// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit: forward-select codes, result
// sources and the scoreboard entry layout.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int T_W   = 2;

  localparam logic [2:0] FW_REG  = 3'd0;
  localparam logic [2:0] FW_ALUM = 3'd1;
  localparam logic [2:0] FW_PC8M = 3'd2;
  localparam logic [2:0] FW_WDW  = 3'd3;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_PC8 = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  typedef struct packed {
    logic [REG_W-1:0] a3;
    logic [T_W-1:0]   tnew;
    src_e             src;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } sb_entry_t;

  // Bypass code for a ready value sitting in the M pipe register.
  function automatic logic [2:0] fw_code_m(input src_e src);
    case (src)
      SRC_ALU: fw_code_m = FW_ALUM;
      SRC_PC8: fw_code_m = FW_PC8M;
      default: fw_code_m = FW_REG;
    endcase
  endfunction

endpackage

// File: rtl/hazard_stage_entry.sv
// One shadow-scoreboard stage: loads the previous stage's entry, optionally
// ageing tnew by one cycle, or takes a bubble.
module hazard_stage_entry
  import hazard_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      bubble_i,
  input  logic      dec_i,
  input  sb_entry_t entry_i,
  output sb_entry_t entry_o
);

  sb_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_i;
    if (dec_i && (entry_i.tnew != '0)) begin
      entry_d.tnew = entry_i.tnew - 1'b1;
    end
    if (bubble_i) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall and bypass-select generation for the 5-stage core, driven by a shadow
// scoreboard of the E, M and W stages that advances with the pipeline.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic [T_W-1:0]   tuse_rs_D,
  input  logic [T_W-1:0]   tuse_rt_D,
  input  logic [REG_W-1:0] a3_D,
  input  logic [T_W-1:0]   tnew_D,
  input  logic [1:0]       src_D,
  output logic             stall,
  output logic [2:0]       ForwardRSD,
  output logic [2:0]       ForwardRTD,
  output logic [2:0]       ForwardRSE,
  output logic [2:0]       ForwardRTE,
  output logic [2:0]       ForwardRTM
);

  sb_entry_t d_entry, e_q, m_q, w_q;

  assign d_entry = '{a3: a3_D, tnew: tnew_D, src: src_e'(src_D), rs: rs_D, rt: rt_D};

  hazard_stage_entry u_entry_e (
    .clk_i(clk), .reset_i(reset), .bubble_i(stall), .dec_i(1'b0),
    .entry_i(d_entry), .entry_o(e_q)
  );

  hazard_stage_entry u_entry_m (
    .clk_i(clk), .reset_i(reset), .bubble_i(1'b0), .dec_i(1'b1),
    .entry_i(e_q), .entry_o(m_q)
  );

  hazard_stage_entry u_entry_w (
    .clk_i(clk), .reset_i(reset), .bubble_i(1'b0), .dec_i(1'b1),
    .entry_i(m_q), .entry_o(w_q)
  );

  // The younger E producer shadows any older M producer of the same register.
  function automatic logic op_stall(input logic [REG_W-1:0] x, input logic [T_W-1:0] tuse,
                                    input sb_entry_t e, input sb_entry_t m);
    if ((x == '0) || (tuse == TUSE_NONE)) begin
      op_stall = 1'b0;
    end else if (e.a3 == x) begin
      op_stall = (e.tnew > tuse);
    end else begin
      op_stall = (m.a3 == x) && (m.tnew > tuse);
    end
  endfunction

  function automatic logic fw_hit(input sb_entry_t s, input logic [REG_W-1:0] x);
    fw_hit = (s.a3 != '0) && (s.a3 == x) && (s.tnew == '0);
  endfunction

  assign stall = !reset && (op_stall(rs_D, tuse_rs_D, e_q, m_q) ||
                            op_stall(rt_D, tuse_rt_D, e_q, m_q));

  always_comb begin
    ForwardRSD = FW_REG;
    ForwardRTD = FW_REG;
    ForwardRSE = FW_REG;
    ForwardRTE = FW_REG;
    ForwardRTM = FW_REG;

    if (!stall && fw_hit(m_q, rs_D)) ForwardRSD = fw_code_m(m_q.src);
    if (!stall && fw_hit(m_q, rt_D)) ForwardRTD = fw_code_m(m_q.src);

    if (fw_hit(m_q, e_q.rs) && (m_q.src != SRC_MEM)) ForwardRSE = fw_code_m(m_q.src);
    else if (fw_hit(w_q, e_q.rs))                   ForwardRSE = FW_WDW;

    if (fw_hit(m_q, e_q.rt) && (m_q.src != SRC_MEM)) ForwardRTE = fw_code_m(m_q.src);
    else if (fw_hit(w_q, e_q.rt))                   ForwardRTE = FW_WDW;

    if (fw_hit(w_q, m_q.rt)) ForwardRTM = FW_WDW;
  end

  // Source operand indices are not needed once an entry reaches W.
  logic unused_w_ops;
  assign unused_w_ops = ^{w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed MIPS hazard sequences plus randomized
// instruction streams checked against a pipeline-level reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, src_D;
  logic       stall;
  logic [2:0] ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .a3_D(a3_D),
    .tnew_D(tnew_D), .src_D(src_D), .stall(stall),
    .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
    .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE), .ForwardRTM(ForwardRTM)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference pipeline: index 0 = E, 1 = M, 2 = W (instruction in flight).
  int sb_a3[3], sb_tn[3], sb_src[3], sb_rs[3], sb_rt[3];
  int o_stall, o_rsd, o_rtd, o_rse, o_rte, o_rtm;

  // Needs a stall when the nearest in-flight writer of x is not ready in time.
  function automatic int need_stall(input int x, input int tuse);
    if (x == 0 || tuse == 3) return 0;
    for (int s = 0; s < 2; s++)
      if (sb_a3[s] == x) return (sb_tn[s] > tuse) ? 1 : 0;
    return 0;
  endfunction

  function automatic int ready_in(input int s, input int x);
    return (sb_a3[s] != 0 && sb_a3[s] == x && sb_tn[s] == 0) ? 1 : 0;
  endfunction

  function automatic int m_code(input int x);
    if (!ready_in(1, x)) return 0;
    if (sb_src[1] == 0) return 1;
    if (sb_src[1] == 1) return 2;
    return 0;
  endfunction

  function automatic int e_code(input int x);
    if (ready_in(1, x) && sb_src[1] != 2) return m_code(x);
    if (ready_in(2, x)) return 3;
    return 0;
  endfunction

  task automatic step(input int rst, input int rs, input int rt, input int tus, input int tut,
                      input int a3, input int tn, input int src);
    int es;
    @(negedge clk);
    reset = (rst != 0); rs_D = rs[4:0]; rt_D = rt[4:0];
    tuse_rs_D = tus[1:0]; tuse_rt_D = tut[1:0];
    a3_D = a3[4:0]; tnew_D = tn[1:0]; src_D = src[1:0];
    #1;
    es = (rst != 0) ? 0 : (need_stall(rs, tus) | need_stall(rt, tut));
    check_eq("stall", stall, es);
    check_eq("fwd_rsd", ForwardRSD, es ? 0 : m_code(rs));
    check_eq("fwd_rtd", ForwardRTD, es ? 0 : m_code(rt));
    check_eq("fwd_rse", ForwardRSE, e_code(sb_rs[0]));
    check_eq("fwd_rte", ForwardRTE, e_code(sb_rt[0]));
    check_eq("fwd_rtm", ForwardRTM, ready_in(2, sb_rt[1]) ? 3 : 0);
    o_stall = stall; o_rsd = ForwardRSD; o_rtd = ForwardRTD;
    o_rse = ForwardRSE; o_rte = ForwardRTE; o_rtm = ForwardRTM;
    @(posedge clk);
    if (rst != 0) begin
      for (int s = 0; s < 3; s++) begin
        sb_a3[s] = 0; sb_tn[s] = 0; sb_src[s] = 0; sb_rs[s] = 0; sb_rt[s] = 0;
      end
    end else begin
      for (int s = 2; s > 0; s--) begin
        sb_a3[s] = sb_a3[s-1]; sb_src[s] = sb_src[s-1];
        sb_rs[s] = sb_rs[s-1]; sb_rt[s] = sb_rt[s-1];
        sb_tn[s] = (sb_tn[s-1] > 0) ? sb_tn[s-1] - 1 : 0;
      end
      if (es != 0) begin
        sb_a3[0] = 0; sb_tn[0] = 0; sb_src[0] = 0; sb_rs[0] = 0; sb_rt[0] = 0;
      end else begin
        sb_a3[0] = a3; sb_tn[0] = tn; sb_src[0] = src; sb_rs[0] = rs; sb_rt[0] = rt;
      end
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 3, 3, 0, 0, 0);
  endtask

  initial begin
    int rs, rt, tus, tut, a3, tn, src, rst, cls;
    for (int s = 0; s < 3; s++) begin
      sb_a3[s] = 0; sb_tn[s] = 0; sb_src[s] = 0; sb_rs[s] = 0; sb_rt[s] = 0;
    end
    reset = 1'b1; rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    a3_D = '0; tnew_D = '0; src_D = '0;
    @(posedge clk);

    // Reset held with hazard-looking inputs, then first cycle after release.
    step(1, 8, 8, 0, 0, 8, 2, 2);
    check_eq("rst_stall", o_stall, 0);
    step(1, 8, 8, 0, 0, 8, 2, 2);
    check_eq("rst_fwd", o_rsd | o_rtd | o_rse | o_rte | o_rtm, 0);
    step(0, 8, 8, 0, 0, 8, 2, 2);
    check_eq("post_rst_stall", o_stall, 0);
    nop(); nop(); nop();

    // addu $8 ; subu $9,$8,$2
    step(0, 1, 2, 1, 1, 8, 1, 0);
    step(0, 8, 2, 1, 1, 9, 1, 0);
    check_eq("alu_alu_stall", o_stall, 0);
    nop();
    check_eq("alu_alu_rse", o_rse, 1);
    nop(); nop();

    // lw $8 ; addu $9,$8,$3
    step(0, 4, 0, 1, 3, 8, 2, 2);
    step(0, 8, 3, 1, 1, 9, 1, 0);
    check_eq("lw_use_stall1", o_stall, 1);
    step(0, 8, 3, 1, 1, 9, 1, 0);
    check_eq("lw_use_stall2", o_stall, 0);
    check_eq("lw_use_bubble_rse", o_rse, 0);
    nop();
    check_eq("lw_use_rse", o_rse, 3);
    nop(); nop();

    // lw $8 ; beq $8,$0
    step(0, 4, 0, 1, 3, 8, 2, 2);
    step(0, 8, 0, 0, 0, 0, 0, 0);
    check_eq("lw_beq_stall1", o_stall, 1);
    step(0, 8, 0, 0, 0, 0, 0, 0);
    check_eq("lw_beq_stall2", o_stall, 1);
    step(0, 8, 0, 0, 0, 0, 0, 0);
    check_eq("lw_beq_stall3", o_stall, 0);
    check_eq("lw_beq_rsd", o_rsd, 0);
    nop(); nop();

    // jal ; jr $31
    step(0, 0, 0, 3, 3, 31, 1, 1);
    step(0, 31, 0, 0, 3, 0, 0, 0);
    check_eq("jal_jr_stall1", o_stall, 1);
    step(0, 31, 0, 0, 3, 0, 0, 0);
    check_eq("jal_jr_stall2", o_stall, 0);
    check_eq("jal_jr_rsd", o_rsd, 2);
    nop(); nop();

    // lw $5 ; sw $5,0($6), then the same with a3 = 0
    for (int k = 0; k < 2; k++) begin
      step(0, 4, 0, 1, 3, (k == 0) ? 5 : 0, (k == 0) ? 2 : 0, 2);
      step(0, 6, 5, 1, 2, 0, 0, 0);
      check_eq("lw_sw_stall", o_stall, 0);
      nop();
      nop();
      check_eq("lw_sw_rtm", o_rtm, (k == 0) ? 3 : 0);
      check_eq("lw_sw_others", o_rsd | o_rtd | o_rse | o_rte, 0);
      nop();
    end

    // Random instruction stream; D inputs held while stalled.
    rs = 0; rt = 0; tus = 3; tut = 3; a3 = 0; tn = 0; src = 0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 59) == 0) ? 1 : 0;
      if (!(o_stall == 1 && i > 0)) begin
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
        tus = $urandom_range(0, 3); tut = $urandom_range(0, 3);
        cls = $urandom_range(0, 3);
        case (cls)
          0: begin a3 = $urandom_range(0, 7); tn = 1; src = 0; end
          1: begin a3 = 31; tn = 1; src = 1; if ($urandom_range(0, 1) == 1) rs = 31; end
          2: begin a3 = $urandom_range(0, 7); tn = 2; src = 2; end
          default: begin a3 = 0; tn = 0; src = 0; end
        endcase
      end
      step(rst, rs, rt, tus, tut, a3, tn, src);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
